// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the RAM boot loader.
package ram_loader_pkg;

    localparam int unsigned DefaultAddrWidth    = 5;
    localparam int unsigned DefaultDataWidth    = 32;
    localparam int unsigned DefaultBytesPerWord = DefaultDataWidth / 8;

    // StVerify is only reachable when RAM_LOADER_VERIFY_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StPack,
        StWrite,
        StDone,
        StVerify
    } state_e;

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Little-endian byte packer: collects BYTES_PER_WORD bytes into one staging word.
// The first byte of a word lands in bits [7:0]; word_full flags the filling transfer.
module ram_loader_byte_packer
    import ram_loader_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = DefaultBytesPerWord
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        take,
    input  logic [7:0]                  byte_in,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_full
);

    localparam int unsigned IdxWidth = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BYTES_PER_WORD - 1);

    logic [IdxWidth-1:0]           idx_q, idx_d;
    logic [8*BYTES_PER_WORD-1:0]   word_q, word_d;

    // Place each accepted byte at its lane and advance the byte index.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d = '0;
        end else if (take) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxWidth'(1);
        end
    end

    // Index and staging registers; the staging word holds through WRITE/VERIFY.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_full = take && !clear && (idx_q == LastIdx);

endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams bytes into a single-port RAM at boot, then hands the port to the host.
// Build macro RAM_LOADER_VERIFY_EN adds a one-cycle read-back VERIFY after every write
// and drives a sticky verify_error; without it verify_error is tied low.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_error,
    input  logic [ADDR_WIDTH-1:0] host_address,
    input  logic [DATA_WIDTH-1:0] host_data_in,
    input  logic                  host_we,
    input  logic                  host_cs,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_cs
);

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   written_q, written_d;
    logic [ADDR_WIDTH:0]   count_clamped;
    logic                  start_ok, take, word_full, last_word;
    logic [DATA_WIDTH-1:0] staged;

    // Clamping to the RAM depth means the address counter never wraps onto live data.
    assign count_clamped = (word_count > Depth) ? Depth : word_count;
    assign start_ok      = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_word     = (written_q + (ADDR_WIDTH + 1)'(1)) == count_q;
    assign take          = byte_valid && byte_ready;

    ram_loader_byte_packer #(
        .BYTES_PER_WORD(BYTES_PER_WORD)
    ) u_packer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (start_ok),
        .take     (take),
        .byte_in  (byte_in),
        .word     (staged),
        .word_full(word_full)
    );

    // Next-state logic: load setup on start, pack, write, optional read-back.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        written_d = written_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    count_d   = count_clamped;
                    addr_d    = '0;
                    written_d = '0;
                    state_d   = (count_clamped == '0) ? StDone : StPack;
                end
            end
            StPack: begin
                if (word_full) state_d = StWrite;
            end
`ifdef RAM_LOADER_VERIFY_EN
            StWrite: begin
                state_d = StVerify;
            end
            // Address advances only after read-back so VERIFY sees the written location.
            StVerify: begin
                addr_d    = addr_q + ADDR_WIDTH'(1);
                written_d = written_q + (ADDR_WIDTH + 1)'(1);
                state_d   = last_word ? StDone : StPack;
            end
`else
            StWrite: begin
                addr_d    = addr_q + ADDR_WIDTH'(1);
                written_d = written_q + (ADDR_WIDTH + 1)'(1);
                state_d   = last_word ? StDone : StPack;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Loader state and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            count_q   <= '0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            written_q <= written_d;
        end
    end

    // Status outputs and RAM port mux: host owns the port whenever the loader is not busy.
    always_comb begin
        busy        = (state_q == StPack) || (state_q == StWrite) || (state_q == StVerify);
        done        = (state_q == StDone);
        byte_ready  = (state_q == StPack);
        ram_address = host_address;
        ram_data_in = host_data_in;
        ram_we      = host_we;
        ram_cs      = host_cs;
        if (busy) begin
            ram_address = addr_q;
            ram_data_in = staged;
            ram_cs      = (state_q == StWrite) || (state_q == StVerify);
            ram_we      = (state_q == StWrite);
        end
    end

`ifdef RAM_LOADER_VERIFY_EN
    logic verify_error_q, verify_error_d;

    // Sticky read-back mismatch flag, cleared only by an accepted start.
    always_comb begin
        verify_error_d = verify_error_q;
        if (start_ok) begin
            verify_error_d = 1'b0;
        end else if ((state_q == StVerify) && (ram_data_out != staged)) begin
            verify_error_d = 1'b1;
        end
    end

    // Verify error register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            verify_error_q <= 1'b0;
        end else begin
            verify_error_q <= verify_error_d;
        end
    end

    assign verify_error = verify_error_q;
`else
    // Read data is only consumed by the host in this build.
    logic unused_ram_data_out;
    assign unused_ram_data_out = ^ram_data_out;
    assign verify_error        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader with a behavioural 32x32 RAM on the RAM port.
// Expected RAM writes are queued at stimulus time; a negedge monitor pops and compares.
module tb_ram_loader;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
`ifdef RAM_LOADER_VERIFY_EN
    localparam int LoadEdges = 11;  // 6 cycles per word
`else
    localparam int LoadEdges = 9;   // 5 cycles per word
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready, busy, done, verify_error;
    logic [AW-1:0] host_address;
    logic [DW-1:0] host_data_in;
    logic          host_we, host_cs;
    logic [DW-1:0] ram_data_out;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_we, ram_cs;

    logic [DW-1:0]    mem [0:(1 << AW) - 1];
    logic             inject;
    logic             flip;
    logic [AW+DW-1:0] exp_q [$];
    int               checks = 0;
    int               errors = 0;
    int               we_count = 0;
    int               cyc = 0;

    always #5 clock = ~clock;

    ram_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .word_count  (word_count),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .done        (done),
        .verify_error(verify_error),
        .host_address(host_address),
        .host_data_in(host_data_in),
        .host_we     (host_we),
        .host_cs     (host_cs),
        .ram_data_out(ram_data_out),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_we      (ram_we),
        .ram_cs      (ram_cs)
    );

    // Behavioural RAM: synchronous write, combinational read; optional bit-0 corruption
    // on the loader's read-back of address 1.
    always @(posedge clock) if (ram_cs && ram_we) mem[ram_address] <= ram_data_in;
    assign flip = inject && busy && ram_cs && !ram_we && (ram_address == AW'(1));
    assign ram_data_out = mem[ram_address] ^ DW'(flip);

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    initial forever begin
        logic [AW+DW-1:0] e;
        @(negedge clock);
        if (ram_cs === 1'b1 && ram_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%h, no write expected",
                         ram_address, ram_data_in);
            end else begin
                e = exp_q.pop_front();
                check("ram_write", 64'({ram_address, ram_data_in}), 64'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_write(input int a, input logic [DW-1:0] d);
        exp_q.push_back({AW'(a), d});
    endtask

    task automatic pulse_start(input int n);
        word_count = (AW + 1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] d);
        push_write(a, d);
        host_address = AW'(a);
        host_data_in = d;
        host_cs = 1'b1;
        host_we = 1'b1;
        tick();
        host_cs = 1'b0;
        host_we = 1'b0;
    endtask

    // Streams bytes; rnd randomises byte_valid; a spurious start pulses at byte index mid.
    task automatic stream(input logic [7:0] bq[$], input bit rnd, input int mid,
                          output int first_edge);
        first_edge = -1;
        for (int i = 0; i < bq.size(); i++) begin
            bit acc;
            bit first;
            int guard;
            acc = 1'b0;
            first = 1'b1;
            guard = 0;
            byte_in = bq[i];
            while (!acc) begin
                byte_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                start = (i == mid) && first;
                if (start) word_count = (AW + 1)'(1);
                first = 1'b0;
                @(negedge clock);
                acc = byte_valid && byte_ready;
                if (acc && first_edge < 0) first_edge = cyc + 1;
                tick();
                guard++;
                if (!acc && guard > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_stall: byte %0d not accepted, ready=%0b", i, byte_ready);
                    byte_valid = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
        end
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edge_no);
        edge_no = -1;
        for (int g = 0; g < 200; g++) begin
            @(negedge clock);
            if (done) begin
                edge_no = cyc;
                break;
            end
        end
        if (edge_no < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=%0b, expected 1 within 200 cycles", done);
        end
        tick();
    endtask

    initial begin
        logic [7:0] b1 [$];
        logic [7:0] bq [$];
        logic [DW-1:0] w0, w31;
        int fe, de, wc, seen;

        reset_n = 1'b0;
        start = 1'b0;
        word_count = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        host_address = '0;
        host_data_in = '0;
        host_we = 1'b0;
        host_cs = 1'b0;
        inject = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        b1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        // Reset state and pass-through while held in reset
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", 64'({byte_ready, busy, done, verify_error}), 64'(0));
        host_address = AW'(9);
        host_data_in = 32'hCAFE_F00D;
        host_cs = 1'b1;
        #1;
        check("reset_passthru", 64'({ram_address, ram_data_in, ram_cs, ram_we}),
              64'({5'd9, 32'hCAFE_F00D, 1'b1, 1'b0}));
        host_cs = 1'b0;
        reset_n = 1'b1;
        tick();

        // Zero-length load: done next cycle, no RAM write
        wc = we_count;
        check("idle_done", 64'(done), 64'(0));
        pulse_start(0);
        check("zero_done", 64'({done, busy}), 64'({1'b1, 1'b0}));
        repeat (3) tick();
        check("zero_no_write", 64'(we_count - wc), 64'(0));

        // Two words at full rate
        push_write(0, 32'h4433_2211);
        push_write(1, 32'h8877_6655);
        pulse_start(2);
        check("start_busy", 64'({busy, done}), 64'({1'b1, 1'b0}));
        stream(b1, 1'b0, -1, fe);
        wait_done(de);
        // done is high in the 11th cycle counting the first-accept cycle as cycle 1
        check("done_latency", 64'(de - fe), 64'(LoadEdges));
        check("full_busy_low", 64'(busy), 64'(0));
        check("full_mem0", 64'(mem[0]), 64'(32'h4433_2211));
        check("full_mem1", 64'(mem[1]), 64'(32'h8877_6655));

        // Clamped load: 40 requested, 32 written, nothing after the last word
        bq.delete();
        for (int j = 0; j < 128; j++) bq.push_back(8'((j * 7 + 3) & 255));
        for (int w = 0; w < 32; w++)
            push_write(w, {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});
        w0  = {bq[3], bq[2], bq[1], bq[0]};
        w31 = {bq[127], bq[126], bq[125], bq[124]};
        pulse_start(40);
        stream(bq, 1'b0, -1, fe);
        byte_valid = 1'b1;
        byte_in = 8'hEE;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (byte_ready) seen++;
        end
        check("ready_after_last", 64'(seen), 64'(0));
        check("clamp_done", 64'(done), 64'(1));
        byte_valid = 1'b0;
        tick();
        check("clamp_mem31", 64'(mem[31]), 64'(w31));
        check("clamp_no_wrap", 64'(mem[0]), 64'(w0));

        // Random valid plus an ignored mid-load start
        host_write(0, 32'hFFFF_0000);
        host_write(1, 32'h0000_FFFF);
        push_write(0, 32'h4433_2211);
        push_write(1, 32'h8877_6655);
        pulse_start(2);
        stream(b1, 1'b1, 4, fe);
        wait_done(de);
        check("rand_mem0", 64'(mem[0]), 64'(32'h4433_2211));
        check("rand_mem1", 64'(mem[1]), 64'(32'h8877_6655));
        check("rand_busy_low", 64'(busy), 64'(0));

        // Reset after 6 bytes of a 2-word load
        host_write(1, 32'hDEAD_BEEF);
        push_write(0, 32'hA4A3_A2A1);
        pulse_start(2);
        bq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        stream(bq, 1'b0, -1, fe);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", 64'({byte_ready, busy, done, verify_error}), 64'(0));
        check("abort_ram_ctrl", 64'({ram_cs, ram_we}), 64'(0));
        tick();
        reset_n = 1'b1;
        host_write(7, 32'h1234_5678);
        tick();
        check("abort_mem0", 64'(mem[0]), 64'(32'hA4A3_A2A1));
        check("abort_mem1", 64'(mem[1]), 64'(32'hDEAD_BEEF));
        check("post_reset_host_wr", 64'(mem[7]), 64'(32'h1234_5678));
        host_address = AW'(1);
        host_cs = 1'b1;
        #1;
        check("post_reset_host_rd", 64'({ram_address, ram_data_out}),
              64'({5'd1, 32'hDEAD_BEEF}));
        host_cs = 1'b0;
        tick();

`ifdef RAM_LOADER_VERIFY_EN
        // Corrupted read-back of word 1 sets a sticky error, cleared by the next start
        push_write(0, 32'h4433_2211);
        push_write(1, 32'h8877_6655);
        inject = 1'b1;
        pulse_start(2);
        stream(b1, 1'b0, -1, fe);
        wait_done(de);
        inject = 1'b0;
        check("verify_latency", 64'(de - fe), 64'(LoadEdges));
        check("verify_err_set", 64'(verify_error), 64'(1));
        repeat (3) tick();
        check("verify_err_sticky", 64'({verify_error, done}), 64'({1'b1, 1'b1}));
        check("verify_mem1", 64'(mem[1]), 64'(32'h8877_6655));
        push_write(0, 32'h0403_0201);
        pulse_start(1);
        check("verify_err_clear", 64'(verify_error), 64'(0));
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        stream(bq, 1'b0, -1, fe);
        wait_done(de);
        check("verify_clean_load", 64'(verify_error), 64'(0));
`else
        check("verify_tied_low", 64'(verify_error), 64'(0));
`endif

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Upstream feeder for the 32x32 single-port RAM.
- Accepts a byte stream over a valid/ready handshake and packs 4 bytes little-endian into 32-bit words.
- Writes the words to RAM at incrementing addresses starting at 0, then signals done.
- Outside a load, passes the host's RAM control signals straight through, so one RAM port serves both boot-time loading and normal access.

Parameters:
- ADDR_WIDTH, 5, RAM address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8.
- BYTES_PER_WORD, DATA_WIDTH/8, derived; not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load.
- word_count  in  ADDR_WIDTH+1  number of words to load; sampled on start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- busy  out  1  load in progress.
- done  out  1  last load completed; held high.
- verify_error  out  1  sticky readback mismatch (see Optional Feature).
- host_address  in  ADDR_WIDTH  host RAM address.
- host_data_in  in  DATA_WIDTH  host write data.
- host_we  in  1  host write enable.
- host_cs  in  1  host chip select.
- ram_data_out  in  DATA_WIDTH  RAM read data; combinational from the RAM.
- ram_address  out  ADDR_WIDTH  to RAM.
- ram_data_in  out  DATA_WIDTH  to RAM.
- ram_we  out  1  to RAM.
- ram_cs  out  1  to RAM.

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - byte_ready, busy, done, verify_error = 0.
  - Address counter, byte index, words-written counter and staging register = 0.
  - Reset mid-load aborts immediately. A partially packed word is discarded. Words already written stay in RAM.
- States: IDLE, PACK, WRITE, DONE (plus VERIFY under the macro).
- IDLE / DONE:
  - RAM ports are a combinational pass-through of the host signals.
  - The host reads ram_data_out directly.
- start in IDLE or DONE:
  - Latch word_count, clamping values >2**ADDR_WIDTH to 2**ADDR_WIDTH.
  - Clear done, clear the address counter.
  - If the latched count is 0, go to DONE next cycle with no writes; otherwise go to PACK with busy=1.
- start while busy is ignored.
- PACK:
  - byte_ready=1.
  - On a transfer (byte_valid && byte_ready), byte k of the word goes to bits [8k+7:8k]; the first byte lands in [7:0].
  - The transfer that fills the last byte moves to WRITE on the next edge.
  - byte_valid low stalls with no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0; ram_cs=1, ram_we=1, ram_address=address counter, ram_data_in=staging register.
  - The RAM captures on the rising edge ending this cycle.
  - Increment the address counter and words-written counter. If words-written equals the latched count, go to DONE; else go to PACK with byte index 0.
- During busy:
  - Host signals are ignored; the RAM is driven only by the loader.
  - In PACK, ram_cs=0 and ram_we=0.
- DONE: busy=0, done=1 until the next start or reset.
- Latency:
  - First byte accepted at the earliest one cycle after start.
  - Each word costs 4 accepted bytes + 1 WRITE cycle, so full-rate streaming gives 5 cycles per word.
  - done rises the cycle after the final WRITE.
- Address range: the clamp guarantees no wrap; address 2**ADDR_WIDTH-1 is the last possible write.

Optional Feature:
- Macro RAM_LOADER_VERIFY_EN.
- Defined:
  - After every WRITE, enter VERIFY for one cycle: ram_cs=1, ram_we=0, same address.
  - Compare ram_data_out to the staging register. On mismatch, set verify_error, which stays sticky until the next start or reset.
  - Continue to PACK or DONE as WRITE would have; cost is 6 cycles per word.
- Undefined: no VERIFY state; verify_error is tied 0. The port is present in both builds.

Decomposition:
- Shared package: state enum (IDLE, PACK, WRITE, DONE, VERIFY), default ADDR_WIDTH/DATA_WIDTH constants, BYTES_PER_WORD.
- Optional sub-module: byte_packer (byte index counter + staging register, emits word_full). The FSM and host mux stay in ram_loader.

Test Plan:
- word_count=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 at full rate -> RAM[0]=0x44332211, RAM[1]=0x88776655, done high 11 cycles after first byte accepted, busy low.
- word_count=40 with 128 bytes -> clamped to 32; RAM[31] holds last word; byte_ready low after byte 128; no address wrap.
- word_count=0, start -> done=1 next cycle, no ram_we pulse.
- byte_valid toggled randomly, plus a start pulse mid-load -> identical RAM contents to the full-rate run; the mid-load start has no effect.
- reset_n low after 6 bytes of a 2-word load -> RAM[0] written, RAM[1] untouched; all outputs 0; host pass-through works immediately after reset.
- RAM_LOADER_VERIFY_EN defined, bench forces ram_data_out bit 0 flipped during VERIFY of word 1 -> verify_error=1 and sticky through done; cleared by next start.
